// File: rtl/remex_target.sv
// remex_target: remote end of the serial expansion link.
// It receives a command frame bit by bit, runs one 16-bit Wishbone B3 cycle,
// and sends back a status byte, followed by read data for a successful read.
module remex_target #(
  parameter int unsigned TIMEOUT = 255,  // max stb_o cycles without ack_i
  parameter int unsigned GAP     = 1023  // max idle cycles between bits inside a frame
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rxd_i,
  input  logic        rxe_i,
  output logic        txd_o,
  output logic        txe_o,
  input  logic        tx_rdy_i,
  output logic [23:0] adr_o,
  output logic [15:0] dat_o,
  input  logic [15:0] dat_i,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [1:0]  sel_o,
  input  logic        ack_i
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  localparam logic [7:0] ST_OK  = 8'hAA;
  localparam logic [7:0] ST_ERR = 8'h55;

  typedef enum logic [2:0] {RX_CMD, RX_ADR, RX_DAT, BUS, TX} state_e;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;      // bit counter, shared by receive and transmit
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d;
  logic [23:0]   adr_q, adr_d;
  logic [15:0]   dat_q, dat_d;
  logic [23:0]   resp_q, resp_d;    // response, MSB is the bit on txd_o
  logic          long_q, long_d;    // response carries 16 bits of read data

  logic in_rx;
  logic bit_ok;

  assign in_rx  = (state_q == RX_CMD) || (state_q == RX_ADR) || (state_q == RX_DAT);
  assign bit_ok = in_rx && rxe_i;

  // Next-state logic: frame decoding, bus cycle control and response shifting.
  always_comb begin
    // NOTE: every variable gets its default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    resp_d  = resp_q;
    long_d  = long_q;

    unique case (state_q)
      RX_CMD: if (bit_ok) begin
        // The first bit of the command is its MSB, the write flag; the rest is ignored.
        if (cnt_q == 5'd0) we_d = rxd_i;
        if (cnt_q == 5'd7) begin
          state_d = RX_ADR;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      RX_ADR: if (bit_ok) begin
        adr_d = {adr_q[22:0], rxd_i};
        if (cnt_q == 5'd23) begin
          state_d = we_q ? RX_DAT : BUS;
          cnt_d   = 5'd0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      RX_DAT: if (bit_ok) begin
        dat_d = {dat_q[14:0], rxd_i};
        if (cnt_q == 5'd15) begin
          state_d = BUS;
          cnt_d   = 5'd0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      BUS: begin
        // An ack in the final timeout cycle still wins.
        if (ack_i) begin
          state_d = TX;
          cnt_d   = 5'd0;
          resp_d  = {ST_OK, (we_q ? 16'h0000 : dat_i)};
          long_d  = !we_q;
        end else if (tmo_q == TMO_LAST) begin
          state_d = TX;
          cnt_d   = 5'd0;
          resp_d  = {ST_ERR, 16'h0000};
          long_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      TX: if (tx_rdy_i) begin
        resp_d = {resp_q[22:0], 1'b0};
        if (cnt_q == (long_q ? 5'd23 : 5'd7)) begin
          state_d = RX_CMD;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = RX_CMD;
        cnt_d   = 5'd0;
      end
    endcase

    // Inter-bit gap watchdog: an idle line in the middle of a frame drops the frame.
    if (!in_rx || bit_ok) begin
      gap_d = '0;
    end else if ((state_q != RX_CMD) || (cnt_q != 5'd0)) begin
      if (gap_q == GAP_LAST) begin
        state_d = RX_CMD;
        cnt_d   = 5'd0;
        gap_d   = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset_i) begin
      state_q <= RX_CMD;
      cnt_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      resp_q  <= '0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      resp_q  <= resp_d;
      long_q  <= long_d;
    end
  end

  // Outputs are decoded from registers only, so they never glitch on inputs.
  assign cyc_o = (state_q == BUS);
  assign stb_o = cyc_o;
  assign we_o  = cyc_o && we_q;
  assign sel_o = {2{cyc_o}};
  assign adr_o = {adr_q[23:1], 1'b0};
  assign dat_o = dat_q;
  assign txe_o = (state_q == TX);
  assign txd_o = txe_o && resp_q[23];

endmodule

// File: tb/tb_remex_target.sv
// tb_remex_target: directed, table-driven bench for remex_target.
module tb_remex_target;

  localparam int TIMEOUT = 255;
  localparam int GAP     = 1023;

  logic        clk_i = 1'b0;
  logic        reset_i, rxd_i, rxe_i, tx_rdy_i, ack_i;
  logic        txd_o, txe_o, we_o, cyc_o, stb_o;
  logic [23:0] adr_o;
  logic [15:0] dat_o, dat_i;
  logic [1:0]  sel_o;

  always #5 clk_i = ~clk_i;

  remex_target #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rxd_i(rxd_i), .rxe_i(rxe_i),
    .txd_o(txd_o), .txe_o(txe_o), .tx_rdy_i(tx_rdy_i),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o), .sel_o(sel_o), .ack_i(ack_i)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] adr;
    logic [15:0] wdat;
    logic [15:0] rdat;
    int          ack_dly;   // ack in stb cycle ack_dly+1; -1 means never
    bit          toggle;    // tx_rdy_i alternates, starting low
    bit          noise;     // rxe_i/rxd_i held high during BUS and TX
    logic [23:0] exp_adr;
    logic [23:0] exp_resp;
    int          exp_len;
    int          exp_stb;
  } vec_t;

  vec_t vecs[7];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      rxe_i = 1'b1;
      rxd_i = v[i];
      tick();
    end
    rxe_i = 1'b0;
    rxd_i = 1'b0;
  endtask

  task automatic run_bus(input vec_t v, output int n_stb, output int bad);
    n_stb = 0;
    bad   = 0;
    while (stb_o && n_stb < TIMEOUT + 8) begin
      n_stb++;
      if (adr_o !== v.exp_adr || we_o !== v.cmd[7] || sel_o !== 2'b11 || cyc_o !== 1'b1 ||
          (v.cmd[7] && dat_o !== v.wdat)) bad++;
      ack_i = (n_stb - 1 == v.ack_dly);
      dat_i = ack_i ? v.rdat : 16'hDEAD;
      rxe_i = v.noise;
      rxd_i = v.noise;
      tick();
    end
    ack_i = 1'b0;
    dat_i = 16'h0000;
    rxe_i = 1'b0;
    rxd_i = 1'b0;
  endtask

  task automatic get_resp(input vec_t v, output logic [23:0] val, output int n,
                          output int hold_bad);
    int   cyc;
    bit   held, phase;
    logic prev_txd;
    val = '0; n = 0; hold_bad = 0; cyc = 0; held = 0; phase = 0; prev_txd = 1'b0;
    while (!txe_o && cyc < 10) begin
      tick();
      cyc++;
    end
    while (txe_o && cyc < 200) begin
      if (held && txd_o !== prev_txd) hold_bad++;
      tx_rdy_i = v.toggle ? phase : 1'b1;
      phase    = !phase;
      rxe_i    = v.noise;
      rxd_i    = v.noise;
      if (tx_rdy_i) begin
        val  = {val[22:0], txd_o};
        n++;
        held = 0;
      end else begin
        held     = 1;
        prev_txd = txd_o;
      end
      tick();
      cyc++;
    end
    tx_rdy_i = 1'b0;
    rxe_i    = 1'b0;
    rxd_i    = 1'b0;
  endtask

  // One complete transaction: frame in, bus cycle, response out, then compare.
  task automatic run_vec(input vec_t v, input string tag);
    int          n_stb, bad, n, hold_bad, k;
    logic [23:0] val;
    send_bits({16'h0, v.cmd}, 8);
    send_bits(v.adr, 24);
    if (v.cmd[7]) send_bits({8'h0, v.wdat}, 16);
    k = 0;
    while (!stb_o && k < 8) begin
      tick();
      k++;
    end
    run_bus(v, n_stb, bad);
    get_resp(v, val, n, hold_bad);
    check({tag, " stb_cycles"}, n_stb, v.exp_stb);
    check({tag, " bus_ctl_bad"}, bad, 0);
    check({tag, " resp_len"}, n, v.exp_len);
    check({tag, " resp_val"}, val, v.exp_resp);
    if (v.toggle) check({tag, " tx_hold_bad"}, hold_bad, 0);
    check({tag, " idle_cyc_txe"}, {cyc_o, txe_o}, 2'b00);
  endtask

  initial begin
    int   seen;
    vec_t v;

    vecs[0] = '{8'h80, 24'h100002, 16'hBEEF, 16'h0000, 2,  0, 0, 24'h100002, 24'h0000AA, 8,  3};
    vecs[1] = '{8'h00, 24'h000010, 16'h0000, 16'h1234, 1,  1, 0, 24'h000010, 24'hAA1234, 24, 2};
    vecs[2] = '{8'h00, 24'h000010, 16'h0000, 16'h0000, -1, 0, 0, 24'h000010, 24'h000055, 8,  TIMEOUT};
    vecs[3] = '{8'h7F, 24'hABCDEF, 16'h0000, 16'hA5C3, 0,  0, 1, 24'hABCDEE, 24'hAAA5C3, 24, 1};
    vecs[4] = '{8'hFF, 24'h00FFFF, 16'h0001, 16'h0000, TIMEOUT - 1, 0, 0, 24'h00FFFE, 24'h0000AA, 8, TIMEOUT};
    vecs[5] = '{8'h80, 24'h123456, 16'h5A5A, 16'h0000, -1, 0, 0, 24'h123456, 24'h000055, 8,  TIMEOUT};
    vecs[6] = '{8'h00, 24'h000002, 16'h0000, 16'hFFFF, TIMEOUT - 1, 1, 0, 24'h000002, 24'hAAFFFF, 24, TIMEOUT};

    reset_i = 1'b1; rxd_i = 1'b0; rxe_i = 1'b0; tx_rdy_i = 1'b0; ack_i = 1'b0; dat_i = '0;
    repeat (3) tick();
    reset_i = 1'b0;
    check("reset_ctl", {cyc_o, stb_o, we_o, sel_o, txe_o, txd_o}, 7'b0);
    check("reset_adr", adr_o, 24'h0);
    check("reset_dat", dat_o, 16'h0);

    // Stray ack while idle must not start anything.
    ack_i = 1'b1;
    seen  = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cyc_o || txe_o) seen++;
    end
    ack_i = 1'b0;
    check("idle_ack_ignored", seen, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Partial frame followed by a full gap is dropped silently.
    send_bits(24'h00, 8);
    send_bits(24'h123, 12);
    seen = 0;
    for (int i = 0; i < GAP + 2; i++) begin
      if (stb_o || txe_o) seen++;
      tick();
    end
    check("gap_quiet", seen, 0);
    v = '{8'h00, 24'h000010, 16'h0000, 16'h0F0F, 0, 0, 0, 24'h000010, 24'hAA0F0F, 24, 1};
    run_vec(v, "after_gap");

    // One cycle short of the gap limit the frame survives.
    send_bits(24'h00, 8);
    send_bits(24'h000, 12);
    repeat (GAP - 1) tick();
    send_bits(24'h020, 12);
    seen = 0;
    while (!stb_o && seen < 8) begin
      tick();
      seen++;
    end
    check("gap_edge_stb", stb_o, 1'b1);
    check("gap_edge_adr", adr_o, 24'h000020);
    ack_i = 1'b1; dat_i = 16'h7E81;
    tick();
    ack_i = 1'b0; dat_i = 16'h0000;
    v = '{8'h00, 24'h000020, 16'h0000, 16'h7E81, 0, 0, 0, 24'h000020, 24'hAA7E81, 24, 1};
    begin
      logic [23:0] val;
      int n, hb;
      get_resp(v, val, n, hb);
      check("gap_edge_resp", val, 24'hAA7E81);
    end

    // Reset in the middle of a bus cycle.
    send_bits(24'h00, 8);
    send_bits(24'h000004, 24);
    check("mid_rst_stb_before", stb_o, 1'b1);
    reset_i = 1'b1;
    tick();
    check("mid_rst_ctl", {cyc_o, stb_o, txe_o}, 3'b000);
    reset_i = 1'b0;
    seen = 0;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      if (stb_o || txe_o) seen++;
      tick();
    end
    check("mid_rst_quiet", seen, 0);
    v = '{8'h00, 24'h000006, 16'h0000, 16'h4321, 0, 0, 0, 24'h000006, 24'hAA4321, 24, 1};
    run_vec(v, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/remex_target.md
REMEX_TARGET -- requirements
Module: remex_target

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles waiting for ack_i before aborting a bus cycle.
REQ-002 Parameter: GAP, default 1023, max cycles between received bits inside a frame before the frame is discarded.
REQ-003 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 rxd_i  input  1  received serial bit, MSB first.
REQ-006 rxe_i  input  1  rxd_i valid this cycle.
REQ-007 txd_o  output  1  transmitted serial bit, MSB first.
REQ-008 txe_o  output  1  txd_o valid.
REQ-009 tx_rdy_i  input  1  downstream accepts txd_o this cycle.
REQ-010 adr_o  output  24  Wishbone B3 byte address; bit 0 always 0.
REQ-011 dat_o  output  16  Wishbone write data.
REQ-012 dat_i  input  16  Wishbone read data.
REQ-013 we_o, cyc_o, stb_o  output  1 each  Wishbone B3 controls.
REQ-014 sel_o  output  2  byte selects; always 2'b11 while stb_o high.
REQ-015 ack_i  input  1  Wishbone B3 acknowledge.

Function
REQ-016 Block SHALL be the remote end of the expansion link: it decodes command frames and initiates one 16-bit Wishbone B3 cycle per frame.
REQ-017 Bit accepted only in cycles with rxe_i=1; shift in MSB first.
REQ-018 Frame: 8-bit command, 24-bit address (3 bytes, MSB byte first), then 16-bit write data only if command bit 7 = 1.
REQ-019 Command bit 7 = we; bits 6:0 ignored; address bit 0 forced to 0 on adr_o.
REQ-020 States: RX_CMD, RX_ADR, RX_DAT, BUS, TX; RX_CMD->RX_ADR after 8 bits; RX_ADR->RX_DAT (write) or BUS (read) after 24 bits; RX_DAT->BUS after 16 bits; BUS->TX on ack_i or timeout; TX->RX_CMD after last response bit transferred.
REQ-021 Entering BUS: cyc_o, stb_o, sel_o=11, we_o, adr_o, dat_o asserted the next cycle and held stable until ack_i sampled high.
REQ-022 Cycle in which ack_i=1: latch dat_i (read), deassert cyc_o/stb_o/we_o next cycle; minimum bus latency 1 cycle after stb_o.
REQ-023 Bus timeout counter counts cycles with stb_o=1; on reaching TIMEOUT without ack_i, drop cyc_o/stb_o and go to TX with error status.
REQ-024 Response: status byte 8'hAA on success, 8'h55 on timeout; for successful reads, followed by 16-bit read data, MSB first; writes and errors send status byte only.
REQ-025 Bit transferred only when txe_o=1 and tx_rdy_i=1; txe_o high continuously in TX; txd_o stable while tx_rdy_i=0.
REQ-026 rxe_i ignored in BUS and TX (bits dropped, no error).
REQ-027 Gap counter reset on each accepted bit; increments in RX_ADR/RX_DAT and in RX_CMD after at least one bit received; on reaching GAP, discard partial frame, return to RX_CMD with bit count 0, no bus cycle, no response.
REQ-028 ack_i seen in the same cycle timeout would expire SHALL count as success.
REQ-029 ack_i outside BUS ignored.

Reset
REQ-030 On reset_i=1: state RX_CMD, all counters 0, cyc_o=stb_o=we_o=0, sel_o=00, adr_o=0, dat_o=0, txe_o=0, txd_o=0.
REQ-031 Reset mid-bus-cycle SHALL drop cyc_o/stb_o the following cycle; in-flight frame and response discarded.

Verification
REQ-032 Write frame 8'h80, 24'h100002, 16'hBEEF; slave acks 2 cycles after stb_o -> adr_o=24'h100002, dat_o=16'hBEEF, we_o=1, sel_o=11; response 8'hAA only.
REQ-033 Read frame 8'h00, 24'h000010; slave returns 16'h1234 with ack -> response bits 8'hAA then 16'h1234, MSB first.
REQ-034 Read frame to unmapped slave (ack_i never) -> stb_o high exactly TIMEOUT cycles, then response 8'h55.
REQ-035 Send 12 address bits then idle GAP cycles -> no stb_o, no txe_o; following valid read frame completes normally.
REQ-036 Read response with tx_rdy_i toggling every other cycle -> 24 bits delivered, values unchanged while tx_rdy_i=0.
REQ-037 Assert reset_i while stb_o=1 -> next cycle cyc_o=stb_o=txe_o=0, state RX_CMD.
